// File: rtl/sb_config_responder.sv
// sb_config_responder
// Configuration-bus responder for one switch box tile. Writes land in a
// shadow register, a global commit pulse moves shadow into the active
// register, and reads are answered one cycle later with a registered
// response. The active word drives the switch box track selects.
module sb_config_responder #(
  parameter logic [15:0] TILE_ID   = 16'h0001,
  parameter logic [31:0] RESET_CFG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] config_addr,
  input  logic [31:0] config_data,
  input  logic        config_write,
  input  logic        config_read,
  input  logic        config_commit,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        cfg_error,
  output logic [31:0] config_sb,
  output logic [1:0]  sel_out_1_0
);

  localparam logic [7:0] FEATURE_SB = 8'h00;
  localparam logic [7:0] REG_SHADOW = 8'h00;
  localparam logic [7:0] REG_ACTIVE = 8'h01;
  localparam logic [7:0] REG_STATUS = 8'h02;

  logic [31:0] shadow;
  logic [31:0] active;

  logic        hit;
  logic        req_clash;
  logic        wr_op;
  logic        rd_op;
  logic        wr_shadow;
  logic        err_set;
  logic        err_clr;
  logic        status_dirty;
  logic [31:0] rd_mux;

  // Address decode, per-index write/read handling and error qualification.
  always_comb begin
    hit          = (config_addr[31:16] == TILE_ID) && (config_addr[15:8] == FEATURE_SB);
    req_clash    = hit && config_write && config_read;
    wr_op        = hit && config_write && !config_read;
    rd_op        = hit && config_read && !config_write;
    status_dirty = (shadow != active);
    wr_shadow    = 1'b0;
    err_set      = req_clash;
    err_clr      = 1'b0;
    rd_mux       = 32'h0;

    if (wr_op) begin
      case (config_addr[7:0])
        REG_SHADOW: wr_shadow = 1'b1;
        // The only accepted status write is the error-clear with bit0 set.
        REG_STATUS: begin
          if (config_data[0]) err_clr = 1'b1;
          else                err_set = 1'b1;
        end
        default:    err_set = 1'b1;
      endcase
    end

    if (rd_op) begin
      case (config_addr[7:0])
        REG_SHADOW: rd_mux = shadow;
        REG_ACTIVE: rd_mux = active;
        REG_STATUS: rd_mux = {30'h0, status_dirty, cfg_error};
        default:    err_set = 1'b1;
      endcase
    end
  end

  // Shadow takes write data; active takes the pre-edge shadow on commit,
  // so a same-cycle write needs a later commit to become live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= RESET_CFG;
      active <= RESET_CFG;
    end else begin
      if (wr_shadow)     shadow <= config_data;
      if (config_commit) active <= shadow;
    end
  end

  // Sticky error flag, cleared only by the status-register clear write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_error <= 1'b0;
    end else if (err_clr) begin
      cfg_error <= 1'b0;
    end else if (err_set) begin
      cfg_error <= 1'b1;
    end
  end

  // One-cycle read response; data holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      read_data  <= 32'h0;
    end else begin
      read_valid <= rd_op;
      if (rd_op) read_data <= rd_mux;
    end
  end

  assign config_sb   = active;
  assign sel_out_1_0 = active[11:10];

endmodule

// File: tb/tb_sb_config_responder.sv
// Testbench for sb_config_responder: directed vector table, reset corner
// cases, then random traffic compared against a behavioural model.
module tb_sb_config_responder;

  localparam logic [15:0] TID  = 16'h0001;
  localparam logic [31:0] RCFG = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic        config_read;
  logic        config_commit;
  logic [31:0] read_data;
  logic        read_valid;
  logic        cfg_error;
  logic [31:0] config_sb;
  logic [1:0]  sel_out_1_0;

  sb_config_responder #(.TILE_ID(TID), .RESET_CFG(RCFG)) dut (
    .clk(clk), .reset(reset),
    .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read),
    .config_commit(config_commit),
    .read_data(read_data), .read_valid(read_valid), .cfg_error(cfg_error),
    .config_sb(config_sb), .sel_out_1_0(sel_out_1_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_sh, m_act, m_rd;
  logic        m_err, m_rv;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        w, r, c;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_sb;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] A(input logic [7:0] idx);
    return {TID, 8'h00, idx};
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic w, input logic r, input logic c,
                              input logic rv, input logic [31:0] rd,
                              input logic err, input logic [31:0] sb);
    vec_t v;
    v.addr = addr; v.data = data; v.w = w; v.r = r; v.c = c;
    v.exp_rv = rv; v.exp_rd = rd; v.exp_err = err; v.exp_sb = sb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh = RCFG; m_act = RCFG; m_err = 1'b0; m_rv = 1'b0; m_rd = 32'h0;
  endtask

  // Applies the configuration-bus rules to the model for one clock edge.
  task automatic model_edge(input logic [31:0] addr, input logic [31:0] data,
                            input logic w, input logic r, input logic c);
    logic        is_hit;
    logic [7:0]  idx;
    logic [31:0] n_sh, n_act;
    logic        n_err;
    is_hit = (addr[31:16] == TID) && (addr[15:8] == 8'h00);
    idx    = addr[7:0];
    n_sh   = m_sh;
    n_act  = c ? m_sh : m_act;
    n_err  = m_err;
    m_rv   = 1'b0;
    if (is_hit && w && r) begin
      n_err = 1'b1;
    end else if (is_hit && w) begin
      if (idx == 8'h00)                 n_sh  = data;
      else if (idx == 8'h02 && data[0]) n_err = 1'b0;
      else                              n_err = 1'b1;
    end else if (is_hit && r) begin
      m_rv = 1'b1;
      if (idx == 8'h00)      m_rd = m_sh;
      else if (idx == 8'h01) m_rd = m_act;
      else if (idx == 8'h02) m_rd = (m_sh != m_act ? 32'd2 : 32'd0) + (m_err ? 32'd1 : 32'd0);
      else begin
        m_rd  = 32'h0;
        n_err = 1'b1;
      end
    end
    m_sh = n_sh; m_act = n_act; m_err = n_err;
  endtask

  task automatic step(input logic [31:0] addr, input logic [31:0] data,
                      input logic w, input logic r, input logic c);
    config_addr = addr; config_data = data;
    config_write = w; config_read = r; config_commit = c;
    @(posedge clk);
    model_edge(addr, data, w, r, c);
    #1;
    config_write = 1'b0; config_read = 1'b0; config_commit = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".read_valid"}, {31'h0, read_valid}, {31'h0, m_rv});
    check({tag, ".read_data"},  read_data, m_rd);
    check({tag, ".cfg_error"},  {31'h0, cfg_error}, {31'h0, m_err});
    check({tag, ".config_sb"},  config_sb, m_act);
    check({tag, ".sel_out"},    {30'h0, sel_out_1_0}, {30'h0, m_act[11:10]});
  endtask

  initial begin
    logic [31:0] WRONG;
    WRONG = 32'h0002_0000;

    // Directed vectors: addr, data, w, r, c | rv, rd, err, config_sb
    vecs.push_back(mk(A(8'h01), 32'h0,         0,1,0, 1, 32'h0,   0, 32'h0));
    vecs.push_back(mk(A(8'h00), 32'h0,         0,0,0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(A(8'h00), 32'h0000_0C00, 1,0,0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(A(8'h02), 32'h0,         0,1,0, 1, 32'h2,   0, 32'h0));
    vecs.push_back(mk(A(8'h00), 32'h0,         0,0,1, 0, 32'h2,   0, 32'h0C00));
    vecs.push_back(mk(A(8'h02), 32'h0,         0,1,0, 1, 32'h0,   0, 32'h0C00));
    vecs.push_back(mk(A(8'h00), 32'h0000_0400, 1,0,1, 0, 32'h0,   0, 32'h0C00));
    vecs.push_back(mk(A(8'h00), 32'h0,         0,0,1, 0, 32'h0,   0, 32'h0400));
    vecs.push_back(mk(WRONG,    32'hFFFF_FFFF, 1,0,0, 0, 32'h0,   0, 32'h0400));
    vecs.push_back(mk(WRONG,    32'h0,         0,1,0, 0, 32'h0,   0, 32'h0400));
    vecs.push_back(mk(A(8'h00), 32'h0,         0,1,0, 1, 32'h400, 0, 32'h0400));
    vecs.push_back(mk(A(8'h01), 32'h5,         1,0,0, 0, 32'h400, 1, 32'h0400));
    vecs.push_back(mk(A(8'h02), 32'h0,         0,1,0, 1, 32'h1,   1, 32'h0400));
    vecs.push_back(mk(A(8'h02), 32'h1,         1,0,0, 0, 32'h1,   0, 32'h0400));
    vecs.push_back(mk(A(8'h00), 32'h0000_AAAA, 1,1,0, 0, 32'h1,   1, 32'h0400));
    vecs.push_back(mk(A(8'h00), 32'h0,         0,1,0, 1, 32'h400, 1, 32'h0400));
    vecs.push_back(mk(A(8'h07), 32'h0,         0,1,0, 1, 32'h0,   1, 32'h0400));
    vecs.push_back(mk(A(8'h02), 32'h0,         1,0,0, 0, 32'h0,   1, 32'h0400));
    vecs.push_back(mk(A(8'h02), 32'h1,         1,0,0, 0, 32'h0,   0, 32'h0400));
    vecs.push_back(mk(A(8'h00), 32'h0000_0800, 1,0,0, 0, 32'h0,   0, 32'h0400));
    vecs.push_back(mk(A(8'h01), 32'h0,         0,1,1, 1, 32'h400, 0, 32'h0800));
    vecs.push_back(mk(A(8'h01), 32'h0,         0,1,0, 1, 32'h800, 0, 32'h0800));

    reset = 1'b1;
    config_addr = 32'h0; config_data = 32'h0;
    config_write = 1'b0; config_read = 1'b0; config_commit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst.read_valid", {31'h0, read_valid}, 32'h0);
    check("rst.read_data",  read_data, 32'h0);
    check("rst.cfg_error",  {31'h0, cfg_error}, 32'h0);
    check("rst.config_sb",  config_sb, RCFG);
    check("rst.sel_out",    {30'h0, sel_out_1_0}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].addr, vecs[i].data, vecs[i].w, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d.read_valid", i), {31'h0, read_valid}, {31'h0, vecs[i].exp_rv});
      check($sformatf("vec%0d.read_data", i),  read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d.cfg_error", i),  {31'h0, cfg_error}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d.config_sb", i),  config_sb, vecs[i].exp_sb);
      check($sformatf("vec%0d.sel_out", i),    {30'h0, sel_out_1_0}, {30'h0, vecs[i].exp_sb[11:10]});
    end

    // Read sampled, then reset asserted while the response is on the bus.
    step(A(8'h00), 32'h0, 0, 1, 0);
    check("inflight.pre_valid", {31'h0, read_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("inflight.valid_dropped", {31'h0, read_valid}, 32'h0);
    check("inflight.read_data",     read_data, 32'h0);
    check("inflight.config_sb",     config_sb, RCFG);
    reset = 1'b0;
    model_reset();
    step(A(8'h00), 32'h0000_0C00, 1, 0, 1);
    step(A(8'h02), 32'h0, 0, 0, 0);

    // Read driven, reset asserted before the edge that would sample it.
    config_addr = A(8'h00); config_read = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("prerst.read_valid", {31'h0, read_valid}, 32'h0);
    check("prerst.cfg_error",  {31'h0, cfg_error}, 32'h0);
    check("prerst.config_sb",  config_sb, RCFG);
    config_read = 1'b0;
    reset = 1'b0;
    model_reset();
    step(A(8'h00), 32'h0, 0, 1, 0);
    check("prerst.shadow", read_data, RCFG);
    check_model("prerst");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] tile;
      logic [7:0]  feat, idx;
      logic [31:0] data;
      int          k;
      tile = ($urandom_range(0, 7) == 0) ? 16'h0002 : TID;
      feat = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
      k = $urandom_range(0, 9);
      if (k < 4)       idx = 8'h00;
      else if (k < 6)  idx = 8'h01;
      else if (k < 8)  idx = 8'h02;
      else if (k == 8) idx = 8'h03;
      else             idx = 8'hFF;
      data = $urandom;
      step({tile, feat, idx}, data,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0));
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_config_responder.md
# sb_config_responder

Configuration-bus responder for one CGRA switch box tile. It decodes writes and reads from the global configuration controller into a shadow/active pair of 32-bit `config_sb` registers and answers reads with a registered response. It drives the live `config_sb` word and the decoded 2-bit track-select fields consumed by the switch box output muxes. This replaces the hard-wired configuration constant with a runtime-programmable one.

## Interface

Parameters:
- `TILE_ID`, default 16'h0001: tile identifier matched against `config_addr[31:16]`.
- `RESET_CFG`, default 32'h0000_0000: reset value of both shadow and active registers.

Ports:
- `clk`  input  1  sole clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `config_addr`  input  32  [31:16] tile id, [15:8] feature id (8'h00 = switch box), [7:0] register index.
- `config_data`  input  32  write data.
- `config_write`  input  1  single-cycle write request.
- `config_read`  input  1  single-cycle read request.
- `config_commit`  input  1  global pulse that copies shadow into active.
- `read_data`  output  32  read response data.
- `read_valid`  output  1  one-cycle response strobe.
- `cfg_error`  output  1  sticky protocol/decode error flag.
- `config_sb`  output  32  active configuration word.
- `sel_out_1_0`  output  2  `config_sb[11:10]`: 0 in_0_0, 1 in_2_0, 2 in_3_0, 3 pe_output_0.

## Operation

- Hit: `config_addr[31:16]==TILE_ID` and `[15:8]==8'h00`. Non-hit requests are ignored silently, with no response and no error.
- Register index 8'h00 is the shadow register (R/W). Index 8'h01 is the active register (read-only). Index 8'h02 is the status register (read-only): bit0 = `cfg_error`, bit1 = shadow≠active, other bits 0.
- Write hit to index 0: shadow <= `config_data`.
- Write hit to index 1 or 2, or to any other index: no state change, and `cfg_error` is set.
- Read hit, any index: response is registered and returned as described under Timing. A read of an undefined index returns 32'h0 and sets `cfg_error`.
- `config_write` and `config_read` both high on a hit: neither operation is performed, `cfg_error` is set, and no response is issued.
- `config_commit`: active <= shadow value as it stood before this cycle's edge. A write in the same cycle lands only in the shadow and needs a later commit. The commit is independent of address.
- `cfg_error` clears only on reset or on a write hit to index 2 with `config_data[0]==1`. That write is the single permitted write to index 2 and does not itself set the error.
- `config_sb` = active register. `sel_out_1_0` is combinational from the active register.

## Timing

- Reset (asynchronous): shadow = active = `RESET_CFG`. `read_data`=0, `read_valid`=0, `cfg_error`=0. A response in flight is dropped.
- Write: shadow updates at the edge that samples `config_write`, and is visible to a read issued in the next cycle.
- Read latency is 1. A request sampled at edge N gives `read_valid`=1 and `read_data` valid in the cycle after edge N, for exactly one cycle.
- `read_data` holds its last value when `read_valid`=0.
- Back-to-back reads are allowed every cycle with no stall. The initiator always accepts responses.
- Commit: the active register and `config_sb` update at the sampling edge, and downstream muxes see the new select in that cycle.
- A read of index 1 issued in the same cycle as a commit returns the pre-commit active value.

## Test plan

- Reset, then read index 1 → `read_valid` one cycle later, `read_data`=32'h0, `sel_out_1_0`=0.
- Write 32'h0000_0C00 to {TILE_ID,8'h00,8'h00} → `config_sb` unchanged. Pulse commit → `config_sb`=32'h0000_0C00 and `sel_out_1_0`=3. Status bit1 reads 1 before the commit and 0 after.
- Write 32'h0000_0400 and commit in the same cycle → active unchanged. Next commit → `sel_out_1_0`=1.
- Write to a wrong TILE_ID → no change, no `read_valid`, `cfg_error`=0. Write to index 1 → `cfg_error`=1. Write 1 to index 2 → `cfg_error`=0.
- Read and write asserted together on a hit → no `read_valid`, shadow unchanged, `cfg_error`=1.
- Issue a read, then assert reset asynchronously before the next edge → `read_valid` stays 0 and all registers equal `RESET_CFG`.
